adpcm_codec: RTL and testbench



---
 rtl/adpcm_pkg.sv | 62 ++++++
 rtl/adpcm_decoder.sv | 23 ++
 rtl/adpcm_encoder.sv | 52 +++++
 rtl/adpcm_codec.sv | 27 ++
 tb/tb_adpcm_codec.sv | 119 +++++++++++
 5 files changed

// File: rtl/adpcm_pkg.sv
// Shared IMA-ADPCM tables and the arithmetic helpers used by both the encoder and the decoder.
// Keeping them here guarantees the two predictors evolve identically.
package adpcm_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int CODE_W    = 4;
  localparam int INDEX_W   = 7;
  localparam int INDEX_MAX = 88;

  localparam int STEP [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767
  };

  localparam int IDX [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  function automatic logic [14:0] step_size(input logic [INDEX_W-1:0] index);
    return 15'(STEP[index]);
  endfunction

  // vp = st/8 + st*mag[2] + st/2*mag[1] + st/4*mag[0], never exceeds 16 bits.
  function automatic logic [15:0] step_vp(input logic [INDEX_W-1:0] index,
                                          input logic [2:0] mag);
    logic [15:0] st;
    logic [15:0] vp;
    st = {1'b0, step_size(index)};
    vp = st >> 3;
    if (mag[2]) vp = vp + st;
    if (mag[1]) vp = vp + (st >> 1);
    if (mag[0]) vp = vp + (st >> 2);
    return vp;
  endfunction

  function automatic logic signed [15:0] pred_update(input logic signed [15:0] pred,
                                                     input logic sign,
                                                     input logic [15:0] vp);
    logic signed [17:0] ext_pred;
    logic signed [17:0] ext_vp;
    logic signed [17:0] sum;
    ext_pred = 18'(pred);
    ext_vp   = $signed({2'b00, vp});
    sum      = sign ? (ext_pred - ext_vp) : (ext_pred + ext_vp);
    if (sum > 18'sd32767)       return 16'sh7FFF;
    else if (sum < -18'sd32768) return 16'sh8000;
    else                        return sum[15:0];
  endfunction

  function automatic logic [INDEX_W-1:0] index_update(input logic [INDEX_W-1:0] index,
                                                      input logic [2:0] mag);
    logic signed [8:0] nxt;
    nxt = $signed({2'b00, index}) + 9'(IDX[mag]);
    if (nxt < 9'sd0)                 return '0;
    else if (nxt > 9'sd88)           return 7'(INDEX_MAX);
    else                             return nxt[INDEX_W-1:0];
  endfunction

endpackage

// File: rtl/adpcm_decoder.sv
// IMA-ADPCM decoder: rebuilds the predicted sample from the registered code stream.
module adpcm_decoder
  import adpcm_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic        [CODE_W-1:0]   code,
  output logic signed [SAMPLE_W-1:0] predsample
);

  logic [INDEX_W-1:0] index;

  always_ff @(posedge clk) begin
    if (reset) begin
      predsample <= '0;
      index      <= '0;
    end else begin
      predsample <= pred_update(predsample, code[3], step_vp(index, code[2:0]));
      index      <= index_update(index, code[2:0]);
    end
  end

endmodule

// File: rtl/adpcm_encoder.sv
// IMA-ADPCM encoder: one 16-bit sample in, one registered 4-bit code out per clock.
module adpcm_encoder
  import adpcm_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [CODE_W-1:0]   code
);

  logic signed [SAMPLE_W-1:0] pred;
  logic        [INDEX_W-1:0]  index;

  logic signed [16:0] diff;
  logic        [16:0] rem;
  logic        [16:0] st;
  logic               sign;
  logic        [2:0]  mag;

  // Successive approximation of |diff| against st, st/2, st/4.
  always_comb begin
    diff = 17'(sample) - 17'(pred);
    sign = diff[16];
    rem  = sign ? 17'(-diff) : 17'(diff);
    st   = {2'b00, step_size(index)};
    mag  = '0;
    if (rem >= st) begin
      mag[2] = 1'b1;
      rem    = rem - st;
    end
    st = st >> 1;
    if (rem >= st) begin
      mag[1] = 1'b1;
      rem    = rem - st;
    end
    st = st >> 1;
    if (rem >= st) mag[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred  <= '0;
      index <= '0;
      code  <= '0;
    end else begin
      pred  <= pred_update(pred, sign, step_vp(index, mag));
      index <= index_update(index, mag);
      code  <= {sign, mag};
    end
  end

endmodule

// File: rtl/adpcm_codec.sv
// Encoder/decoder loopback: the registered code is both a block output and the decoder input,
// so predsample trails the encoder predictor by exactly one cycle.
module adpcm_codec
  import adpcm_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [CODE_W-1:0]   code,
  output logic signed [SAMPLE_W-1:0] predsample
);

  adpcm_encoder u_encoder (
    .clk    (clk),
    .reset  (reset),
    .sample (sample),
    .code   (code)
  );

  adpcm_decoder u_decoder (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .predsample (predsample)
  );

endmodule

// File: tb/tb_adpcm_codec.sv
// Directed bench for adpcm_codec with hand-computed codes and reconstructions.
module tb_adpcm_codec;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sample = '0;
  logic        [3:0]  code;
  logic signed [15:0] predsample;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  adpcm_codec dut (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .code       (code),
    .predsample (predsample)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic tick(input logic [15:0] value);
    @(negedge clk);
    reset  = 1'b0;
    sample = value;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset  = 1'b1;
    sample = '0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Ramp k -> {k,k}; codes and decoder outputs worked out by hand from the IMA tables.
  task automatic run_ramp(input string tag);
    logic [15:0] ramp_ps [0:4];
    ramp_ps = '{16'd0, 16'd0, 16'd11, 16'd41, 16'd104};
    exp_q = {16'h0, 16'h7, 16'h7, 16'h7, 16'h7};
    for (int k = 0; k < 5; k++) begin
      tick({8'(k), 8'(k)});
      check({tag, "_code"}, {12'h0, code}, exp_q.pop_front());
      check({tag, "_pred"}, predsample, ramp_ps[k]);
    end
  endtask

  initial begin
    logic signed [15:0] prev;
    logic               seen_min;

    do_reset(2);
    check("reset_code", {12'h0, code}, 16'h0);
    check("reset_pred", predsample, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      tick(16'h0000);
      check("zero_code", {12'h0, code}, 16'h0);
      check("zero_pred", predsample, 16'h0000);
    end

    do_reset(1);
    tick(16'h7F7F);
    check("pos_code0", {12'h0, code}, 16'h7);
    check("pos_pred0", predsample, 16'h0000);
    tick(16'h7F7F);
    check("pos_code1", {12'h0, code}, 16'h7);
    check("pos_pred1", predsample, 16'h000B);

    do_reset(1);
    tick(16'h8080);
    check("neg_code0", {12'h0, code}, 16'hF);
    tick(16'h8080);
    check("neg_code1", {12'h0, code}, 16'hF);
    check("neg_pred1", predsample, 16'hFFF5);

    do_reset(1);
    run_ramp("ramp1");
    do_reset(1);
    check("midrst_code", {12'h0, code}, 16'h0);
    check("midrst_pred", predsample, 16'h0000);
    run_ramp("ramp2");

    do_reset(1);
    prev = '0;
    for (int i = 0; i < 60; i++) begin
      tick(16'h7FFF);
      check("rise_mono", {15'h0, predsample >= prev}, 16'h1);
      prev = predsample;
    end
    check("rise_sat_pred", predsample, 16'h7FFF);
    check("rise_sat_code", {12'h0, code}, 16'h0);

    seen_min = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(16'h8000);
      if (!seen_min) check("fall_mono", {15'h0, predsample <= prev}, 16'h1);
      else           check("fall_nowrap", {15'h0, predsample < 0}, 16'h1);
      if (predsample == 16'sh8000) seen_min = 1'b1;
      prev = predsample;
    end
    check("fall_reached_min", {15'h0, seen_min}, 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
